// File: rtl/ro_pkg.sv
// Shared types and helpers for the readout slot generators.
package ro_pkg;

  localparam logic MODE_PASS  = 1'b0;
  localparam logic MODE_LATCH = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } slot_state_e;

  // Counter width able to hold the value win (0..win inclusive).
  function automatic int cnt_w(input int win);
    return $clog2(win + 1);
  endfunction

endpackage

// File: rtl/gray_edge_det.sv
// Detects any toggle of gray[IDX], suppressed during the first cycle after reset.
module gray_edge_det #(
  parameter int GW  = 17,
  parameter int IDX = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [GW-1:0] gray,
  output logic          tog
);

  // Bit selection through a one-hot mask keeps the whole bus in the cone.
  localparam logic [GW-1:0] SEL_MASK = GW'(1) << IDX;

  logic g_q;
  logic primed;
  logic g_sel;

  assign g_sel = |(gray & SEL_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q    <= 1'b0;
      primed <= 1'b0;
    end else begin
      g_q    <= g_sel;
      primed <= 1'b1;
    end
  end

  assign tog = primed & (g_sel ^ g_q);

endmodule

// File: rtl/ro_slot_gen.sv
// Opens a WIN-cycle readout slot on each toggle of gray[IDX]; drives live or latched channel data.
module ro_slot_gen
  import ro_pkg::*;
#(
  parameter int NCH = 2,
  parameter int GW  = 17,
  parameter int IDX = 5,
  parameter int WIN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic [GW-1:0]  gray,
  input  logic [NCH-1:0] in_pol,
  input  logic [NCH-1:0] in_pol_eve,
  input  logic           clr_ovr,
  output logic [NCH-1:0] out_pol,
  output logic [NCH-1:0] out_pol_eve,
  output logic           oe,
  output logic           strb,
  output logic           ovr
);

  localparam int            CW   = cnt_w(WIN);
  localparam logic [CW-1:0] LAST = CW'(WIN - 1);

  if (IDX < 0 || IDX >= GW) begin : g_bad_idx
    $error("ro_slot_gen: IDX must lie in 0..GW-1");
  end
  if (WIN < 1 || WIN > 255) begin : g_bad_win
    $error("ro_slot_gen: WIN must lie in 1..255");
  end

  logic tog;

  gray_edge_det #(
    .GW (GW),
    .IDX(IDX)
  ) u_edge (
    .clk (clk),
    .rst (rst),
    .gray(gray),
    .tog (tog)
  );

  slot_state_e    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           strb_q, strb_d;
  logic           ovr_q, ovr_set;
  logic           load;
  logic           open;
  logic           mode_q;
  logic [NCH-1:0] hold_pol_q, hold_eve_q;

  // en only gates slot opening; a running slot ignores it.
  assign open = tog & en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strb_d  = 1'b0;
    ovr_set = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (open) begin
          state_d = SLOT;
          cnt_d   = '0;
          strb_d  = 1'b1;
          load    = 1'b1;
        end
      end
      SLOT: begin
        if (open) begin
          // Restart at the natural end is a legal back-to-back slot.
          cnt_d   = '0;
          strb_d  = 1'b1;
          load    = 1'b1;
          ovr_set = (cnt_q != LAST);
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      strb_q     <= 1'b0;
      ovr_q      <= 1'b0;
      mode_q     <= MODE_PASS;
      hold_pol_q <= '0;
      hold_eve_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strb_q  <= strb_d;
      if (ovr_set)      ovr_q <= 1'b1;
      else if (clr_ovr) ovr_q <= 1'b0;
      if (load) begin
        mode_q     <= mode;
        hold_pol_q <= in_pol;
        hold_eve_q <= in_pol_eve;
      end
    end
  end

  assign oe   = (state_q == SLOT);
  assign strb = strb_q;
  assign ovr  = ovr_q;

  always_comb begin
    out_pol     = '0;
    out_pol_eve = '0;
    if (oe) begin
      if (mode_q == MODE_LATCH) begin
        out_pol     = hold_pol_q;
        out_pol_eve = hold_eve_q;
      end else begin
        out_pol     = in_pol;
        out_pol_eve = in_pol_eve;
      end
    end
  end

endmodule

// File: tb/tb_ro_slot_gen.sv
// Directed bench for ro_slot_gen: main instance (IDX=5, WIN=4) and a free-running instance (IDX=0, WIN=2).
module tb_ro_slot_gen;

  logic        clk = 1'b0;
  logic        rst, en, mode, clr_ovr;
  logic [16:0] gray, gray_b;
  logic [1:0]  in_pol, in_pol_eve;
  logic [1:0]  out_pol, out_pol_eve, out_pol_b, out_pol_eve_b;
  logic        oe, strb, ovr, oe_b, strb_b, ovr_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ro_slot_gen #(.NCH(2), .GW(17), .IDX(5), .WIN(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .gray(gray),
    .in_pol(in_pol), .in_pol_eve(in_pol_eve), .clr_ovr(clr_ovr),
    .out_pol(out_pol), .out_pol_eve(out_pol_eve), .oe(oe), .strb(strb), .ovr(ovr)
  );

  ro_slot_gen #(.NCH(2), .GW(17), .IDX(0), .WIN(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .gray(gray_b),
    .in_pol(in_pol), .in_pol_eve(in_pol_eve), .clr_ovr(clr_ovr),
    .out_pol(out_pol_b), .out_pol_eve(out_pol_eve_b), .oe(oe_b), .strb(strb_b), .ovr(ovr_b)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flip_idx();
    gray = gray ^ 17'h00020;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b0; clr_ovr = 1'b0;
    gray = 17'h00020; gray_b = '0; in_pol = 2'b11; in_pol_eve = 2'b11;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", oe); end
    checks++; if (strb !== 1'b0) begin errors++; $display("FAIL reset_strb got=%b exp=0", strb); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
    checks++; if (out_pol !== 2'b00 || out_pol_eve !== 2'b00) begin
      errors++; $display("FAIL reset_out got=%b/%b exp=00/00", out_pol, out_pol_eve); end
    checks++; if (oe_b !== 1'b0) begin errors++; $display("FAIL reset_oe_b got=%b exp=0", oe_b); end
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (oe !== 1'b0 || strb !== 1'b0) begin
        errors++; $display("FAIL release_no_slot k=%0d got oe=%b strb=%b exp 0/0", k, oe, strb); end
      next_cycle();
    end
  endtask

  task automatic test_latch();
    mode = 1'b1; in_pol = 2'b10; in_pol_eve = 2'b01;
    flip_idx();
    @(negedge clk);
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL latch_pre_oe got=%b exp=0", oe); end
    next_cycle();
    in_pol = 2'b01; in_pol_eve = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (oe !== (k <= 4)) begin errors++; $display("FAIL latch_oe k=%0d got=%b exp=%b", k, oe, k <= 4); end
      checks++; if (strb !== (k == 1)) begin errors++; $display("FAIL latch_strb k=%0d got=%b exp=%b", k, strb, k == 1); end
      checks++; if (out_pol !== ((k <= 4) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL latch_pol k=%0d got=%b exp=%b", k, out_pol, (k <= 4) ? 2'b10 : 2'b00); end
      checks++; if (out_pol_eve !== ((k <= 4) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL latch_eve k=%0d got=%b exp=%b", k, out_pol_eve, (k <= 4) ? 2'b01 : 2'b00); end
      next_cycle();
    end
  endtask

  task automatic test_pass();
    logic [1:0] p;
    mode = 1'b0; in_pol = 2'b11; in_pol_eve = 2'b11;
    flip_idx();
    @(negedge clk);
    checks++; if (out_pol !== 2'b00) begin errors++; $display("FAIL pass_pre got=%b exp=00", out_pol); end
    next_cycle();
    for (int k = 1; k <= 5; k++) begin
      p = 2'(k);
      in_pol = p; in_pol_eve = ~p;
      @(negedge clk);
      checks++; if (out_pol !== ((k <= 4) ? p : 2'b00)) begin
        errors++; $display("FAIL pass_pol k=%0d got=%b exp=%b", k, out_pol, (k <= 4) ? p : 2'b00); end
      checks++; if (out_pol_eve !== ((k <= 4) ? ~p : 2'b00)) begin
        errors++; $display("FAIL pass_eve k=%0d got=%b exp=%b", k, out_pol_eve, (k <= 4) ? ~p : 2'b00); end
      next_cycle();
    end
  endtask

  task automatic test_restart();
    logic [1:0] ep;
    mode = 1'b1; in_pol = 2'b01; in_pol_eve = 2'b00;
    flip_idx();
    next_cycle();
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) begin flip_idx(); in_pol = 2'b10; end
      else in_pol = 2'b11;
      ep = (k <= 2) ? 2'b01 : ((k <= 6) ? 2'b10 : 2'b00);
      @(negedge clk);
      checks++; if (oe !== (k <= 6)) begin errors++; $display("FAIL restart_oe k=%0d got=%b exp=%b", k, oe, k <= 6); end
      checks++; if (strb !== (k == 1 || k == 3)) begin
        errors++; $display("FAIL restart_strb k=%0d got=%b exp=%b", k, strb, k == 1 || k == 3); end
      checks++; if (ovr !== (k >= 3)) begin errors++; $display("FAIL restart_ovr k=%0d got=%b exp=%b", k, ovr, k >= 3); end
      checks++; if (out_pol !== ep) begin errors++; $display("FAIL restart_pol k=%0d got=%b exp=%b", k, out_pol, ep); end
      next_cycle();
    end
    clr_ovr = 1'b1;
    @(negedge clk);
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL clr_pending got=%b exp=1", ovr); end
    next_cycle();
    clr_ovr = 1'b0;
    @(negedge clk);
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL clr_done got=%b exp=0", ovr); end
    next_cycle();
    // Overrun with clr_ovr asserted in the same cycle: set must win.
    flip_idx();
    next_cycle();
    flip_idx(); clr_ovr = 1'b1;
    next_cycle();
    clr_ovr = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL set_wins k=%0d got=%b exp=1", k, ovr); end
      checks++; if (oe !== (k <= 5)) begin errors++; $display("FAIL set_wins_oe k=%0d got=%b exp=%b", k, oe, k <= 5); end
      next_cycle();
    end
    clr_ovr = 1'b1;
    next_cycle();
    clr_ovr = 1'b0;
    @(negedge clk);
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL set_wins_clr got=%b exp=0", ovr); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; in_pol = 2'b11; in_pol_eve = 2'b00;
    flip_idx();
    next_cycle();
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) flip_idx();
      @(negedge clk);
      checks++; if (oe !== (k <= 8)) begin errors++; $display("FAIL b2b_oe k=%0d got=%b exp=%b", k, oe, k <= 8); end
      checks++; if (strb !== (k == 1 || k == 5)) begin
        errors++; $display("FAIL b2b_strb k=%0d got=%b exp=%b", k, strb, k == 1 || k == 5); end
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL b2b_ovr k=%0d got=%b exp=0", k, ovr); end
      checks++; if (out_pol !== ((k <= 8) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL b2b_pol k=%0d got=%b exp=%b", k, out_pol, (k <= 8) ? 2'b11 : 2'b00); end
      next_cycle();
    end
  endtask

  task automatic test_en_drop();
    mode = 1'b1; in_pol = 2'b01;
    flip_idx();
    next_cycle();
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) en = 1'b0;
      if (k == 6) flip_idx();
      @(negedge clk);
      checks++; if (oe !== (k <= 4)) begin errors++; $display("FAIL en_drop_oe k=%0d got=%b exp=%b", k, oe, k <= 4); end
      checks++; if (strb !== (k == 1)) begin errors++; $display("FAIL en_drop_strb k=%0d got=%b exp=%b", k, strb, k == 1); end
      next_cycle();
    end
    en = 1'b1;
    next_cycle();
  endtask

  task automatic test_rst_mid_slot();
    mode = 1'b1; in_pol = 2'b11; in_pol_eve = 2'b11;
    flip_idx();
    next_cycle();
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) flip_idx();
      if (k == 2) rst = 1'b1;
      if (k == 4) rst = 1'b0;
      @(negedge clk);
      if (k == 2) begin
        checks++; if (oe !== 1'b1 || strb !== 1'b1 || ovr !== 1'b1 || out_pol !== 2'b11) begin
          errors++; $display("FAIL rst_pre got oe=%b strb=%b ovr=%b pol=%b exp 1/1/1/11", oe, strb, ovr, out_pol); end
      end else if (k == 3) begin
        checks++; if (oe !== 1'b0 || strb !== 1'b0 || ovr !== 1'b0 || out_pol !== 2'b00 || out_pol_eve !== 2'b00) begin
          errors++; $display("FAIL rst_mid got oe=%b strb=%b ovr=%b pol=%b eve=%b exp all 0",
                             oe, strb, ovr, out_pol, out_pol_eve); end
      end else if (k >= 4) begin
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL rst_after k=%0d got=%b exp=0", k, oe); end
      end
      next_cycle();
    end
  endtask

  task automatic test_free_run();
    mode = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      gray_b = 17'(n ^ (n >> 1));
      @(negedge clk);
      if (n == 1) begin
        checks++; if (oe_b !== 1'b0) begin errors++; $display("FAIL free_first got=%b exp=0", oe_b); end
      end else begin
        checks++; if (oe_b !== 1'b1) begin errors++; $display("FAIL free_oe n=%0d got=%b exp=1", n, oe_b); end
        checks++; if (strb_b !== (n % 2 == 0)) begin
          errors++; $display("FAIL free_strb n=%0d got=%b exp=%b", n, strb_b, n % 2 == 0); end
        checks++; if (ovr_b !== 1'b0) begin errors++; $display("FAIL free_ovr n=%0d got=%b exp=0", n, ovr_b); end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_latch();
    test_pass();
    test_restart();
    test_back_to_back();
    test_en_drop();
    test_rst_mid_slot();
    test_free_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
